// File: rtl/fast_keypoint_scheduler.sv
// fast_keypoint_scheduler: qualifies FAST/NMS keypoints inside the border window,
// queues {y,x} in a FIFO and streams them out over a valid/ready handshake with
// per-frame count, overflow and end-of-frame reporting.
// Optional feature macro: FAST_KP_SCORE_EN adds o_kp_score (40-bit FIFO entries).
module fast_keypoint_scheduler #(
    parameter int unsigned P_IMG_WIDTH  = 640,
    parameter int unsigned P_IMG_HEIGHT = 480,
    parameter int unsigned P_BORDER     = 16,
    parameter int unsigned P_FIFO_DEPTH = 64,
    parameter int unsigned P_MAX_KP     = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fast_vs,
    input  logic        i_fast_hs,
    input  logic        i_fast_en,
    input  logic [7:0]  i_fast_data,
    output logic        o_kp_valid,
    input  logic        i_kp_ready,
    output logic [15:0] o_kp_x,
    output logic [15:0] o_kp_y,
    output logic        o_frame_done,
    output logic        o_frame_late,
    output logic [15:0] o_kp_count,
`ifdef FAST_KP_SCORE_EN
    output logic [7:0]  o_kp_score,
`endif
    output logic        o_overflow
);

    localparam int unsigned AW = $clog2(P_FIFO_DEPTH);
`ifdef FAST_KP_SCORE_EN
    localparam int unsigned DW = 40;
`else
    localparam int unsigned DW = 32;
`endif
    localparam logic [15:0] X_MIN  = 16'(P_BORDER);
    localparam logic [15:0] X_MAX  = 16'(P_IMG_WIDTH - 1 - P_BORDER);
    localparam logic [15:0] Y_MIN  = 16'(P_BORDER);
    localparam logic [15:0] Y_MAX  = 16'(P_IMG_HEIGHT - 1 - P_BORDER);
    localparam logic [15:0] KP_MAX = 16'(P_MAX_KP);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic            vs_q, hs_q;
    logic [15:0]     x_q, x_d, y_q, y_d;
    logic [15:0]     kp_count_q, kp_count_d;
    logic            overflow_q, overflow_d;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]   mem [P_FIFO_DEPTH];
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;

    logic            vs_rise, vs_fall, hs_rise, hs_fall, active;
    logic [15:0]     x_cur;
    logic            in_win, kp_hit, full, wr_en, pop, out_xfer, mem_empty;
    logic [AW:0]     mem_cnt;
    logic [AW+1:0]   occ;
    logic [DW-1:0]   wr_data, rd_data;

    assign vs_rise = i_fast_vs & ~vs_q;
    assign vs_fall = ~i_fast_vs & vs_q;
    assign hs_rise = i_fast_hs & ~hs_q;
    assign hs_fall = ~i_fast_hs & hs_q;
    assign active  = (state_q == StActive);

    // The first pixel of a line shares its cycle with the hs rising edge, so it is column 0.
    assign x_cur  = hs_rise ? 16'd0 : x_q;
    assign in_win = (x_cur >= X_MIN) && (x_cur <= X_MAX) && (y_q >= Y_MIN) && (y_q <= Y_MAX);
    assign kp_hit = active && i_fast_en && (i_fast_data != 8'd0) && in_win &&
                    (kp_count_q < KP_MAX);

    // Capacity counts the output register as one slot; a beat leaving this cycle frees one.
    assign mem_cnt   = wr_ptr_q - rd_ptr_q;
    assign mem_empty = (mem_cnt == '0);
    assign out_xfer  = out_valid_q && i_kp_ready;
    assign occ       = {1'b0, mem_cnt} + {{(AW + 1){1'b0}}, out_valid_q};
    assign full      = (occ >= (AW + 2)'(P_FIFO_DEPTH)) && !out_xfer;
    assign wr_en     = kp_hit && !full;
    assign pop       = !mem_empty && (!out_valid_q || i_kp_ready);

`ifdef FAST_KP_SCORE_EN
    assign wr_data    = {i_fast_data, y_q, x_cur};
    assign o_kp_score = out_data_q[39:32];
`else
    assign wr_data    = {y_q, x_cur};
`endif
    assign rd_data    = mem[rd_ptr_q[AW-1:0]];
    assign o_kp_valid = out_valid_q;
    assign o_kp_x     = out_data_q[15:0];
    assign o_kp_y     = out_data_q[31:16];
    assign o_kp_count = kp_count_q;
    assign o_overflow = overflow_q;

    // Frame FSM next state and end-of-frame reporting.
    always_comb begin
        state_d      = state_q;
        o_frame_done = 1'b0;
        o_frame_late = 1'b0;
        unique case (state_q)
            StIdle:   if (vs_rise) state_d = StActive;
            StActive: if (vs_fall) state_d = StDrain;
            StDrain: begin
                if (vs_rise) begin
                    // New frame before the queue emptied: report late, keep the entries.
                    o_frame_done = 1'b1;
                    o_frame_late = 1'b1;
                    state_d      = StActive;
                end else if (mem_empty && !out_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                o_frame_done = 1'b1;
                state_d      = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    // Pixel position counters and per-frame keypoint bookkeeping.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        kp_count_d = kp_count_q;
        overflow_d = overflow_q;
        if (vs_rise) begin
            y_d        = 16'd0;
            kp_count_d = 16'd0;
            overflow_d = 1'b0;
        end
        if (active) begin
            if (hs_rise)   x_d = 16'd0;
            if (i_fast_en) x_d = x_cur + 16'd1;
            if (hs_fall)   y_d = y_q + 16'd1;
            if (wr_en)     kp_count_d = kp_count_q + 16'd1;
            if (kp_hit && full) overflow_d = 1'b1;
        end
    end

    // State, edge-detect, counter and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            // vs_q resets high so a frame already in progress is not seen as a new rising edge.
            vs_q       <= 1'b1;
            hs_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            kp_count_q <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= i_fast_vs;
            hs_q       <= i_fast_hs;
            x_q        <= x_d;
            y_q        <= y_d;
            kp_count_q <= kp_count_d;
            overflow_q <= overflow_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    // Output register: refills from the FIFO head whenever it is empty or being taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_data;
        end else if (i_kp_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fast_keypoint_scheduler.sv
// Directed bench for fast_keypoint_scheduler: table of single-keypoint frames plus
// hand-written sequences for backpressure, keypoint cap, late frame and mid-frame reset.
module tb_fast_keypoint_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0, hs = 1'b0, en = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        kp_ready = 1'b1;
    logic        kp_valid, frame_done, frame_late, overflow;
    logic [15:0] kp_x, kp_y, kp_count;
`ifdef FAST_KP_SCORE_EN
    logic [7:0]  kp_score;
`endif

    always #5 clk = ~clk;

    fast_keypoint_scheduler dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fast_vs    (vs),
        .i_fast_hs    (hs),
        .i_fast_en    (en),
        .i_fast_data  (data),
        .o_kp_valid   (kp_valid),
        .i_kp_ready   (kp_ready),
        .o_kp_x       (kp_x),
        .o_kp_y       (kp_y),
        .o_frame_done (frame_done),
        .o_frame_late (frame_late),
        .o_kp_count   (kp_count),
`ifdef FAST_KP_SCORE_EN
        .o_kp_score   (kp_score),
`endif
        .o_overflow   (overflow)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int drv_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int cyc;
    } beat_t;
    beat_t got_q[$];

    // Output monitor: logs transfers and counts any change while stalled.
    logic        stall_prev = 1'b0;
    logic [15:0] stall_x = '0, stall_y = '0;
    int          stall_bad = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev && (!kp_valid || kp_x != stall_x || kp_y != stall_y))
                stall_bad <= stall_bad + 1;
            if (kp_valid && kp_ready)
                got_q.push_back('{x: int'(kp_x), y: int'(kp_y), cyc: cyc});
            stall_prev <= kp_valid && !kp_ready;
            stall_x    <= kp_x;
            stall_y    <= kp_y;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blank_lines(input int n);
        for (int i = 0; i < n; i++) begin
            hs = 1'b1;
            step();
            hs = 1'b0;
            step();
        end
    endtask

    // One line of n pixels; columns lo..hi carry score, the rest are zero.
    task automatic pixel_line(input int n, input int lo, input int hi, input logic [7:0] score);
        hs = 1'b1;
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            data = (i >= lo && i <= hi) ? score : 8'd0;
            if (i == lo) drv_cyc = cyc;
            step();
        end
        hs   = 1'b0;
        en   = 1'b0;
        data = 8'd0;
        step();
    endtask

    task automatic start_frame();
        vs = 1'b1;
        step();
    endtask

    task automatic end_frame();
        vs = 1'b0;
        step();
    endtask

    task automatic wait_done(output logic found, output logic late, output int dcyc);
        found = 1'b0;
        late  = 1'b0;
        dcyc  = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (frame_done) begin
                found = 1'b1;
                late  = frame_late;
                dcyc  = cyc;
            end else begin
                step();
            end
        end
        step();
        step();
    endtask

    task automatic check_run(input string name, input int first_x, input int n_exp);
        int bad;
        bad = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i].x != first_x + i || got_q[i].y != 16) bad++;
        check({name, "_beats"}, got_q.size(), n_exp);
        check({name, "_order"}, bad, 0);
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [7:0] score;
        int         exp_n;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic found, late;
        int   dcyc, bad;
        int   exp_x[7];

        vecs[0] = '{x: 100, y: 50,  score: 8'hA0, exp_n: 1};
        vecs[1] = '{x: 10,  y: 50,  score: 8'h10, exp_n: 0};
        vecs[2] = '{x: 100, y: 470, score: 8'h10, exp_n: 0};
        vecs[3] = '{x: 16,  y: 16,  score: 8'h01, exp_n: 1};
        vecs[4] = '{x: 623, y: 463, score: 8'hFF, exp_n: 1};
        vecs[5] = '{x: 15,  y: 16,  score: 8'h01, exp_n: 0};
        vecs[6] = '{x: 624, y: 100, score: 8'h01, exp_n: 0};
        vecs[7] = '{x: 16,  y: 15,  score: 8'h01, exp_n: 0};
        vecs[8] = '{x: 200, y: 464, score: 8'h01, exp_n: 0};
        vecs[9] = '{x: 300, y: 200, score: 8'h00, exp_n: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", kp_valid, 0);
        check("rst_x", kp_x, 0);
        check("rst_y", kp_y, 0);
        check("rst_done", frame_done, 0);
        check("rst_late", frame_late, 0);
        check("rst_count", kp_count, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        step();
        step();

        // Single-keypoint frames, including window boundaries
        for (int v = 0; v < 10; v++) begin
            got_q.delete();
            kp_ready = 1'b1;
            start_frame();
            blank_lines(vecs[v].y);
            pixel_line(vecs[v].x + 1, vecs[v].x, vecs[v].x, vecs[v].score);
            end_frame();
            wait_done(found, late, dcyc);
            check($sformatf("v%0d_done", v), found, 1);
            check($sformatf("v%0d_late", v), late, 0);
            check($sformatf("v%0d_count", v), kp_count, vecs[v].exp_n);
            check($sformatf("v%0d_ovf", v), overflow, 0);
            check($sformatf("v%0d_beats", v), got_q.size(), vecs[v].exp_n);
            if (vecs[v].exp_n == 1 && got_q.size() == 1) begin
                check($sformatf("v%0d_x", v), got_q[0].x, vecs[v].x);
                check($sformatf("v%0d_y", v), got_q[0].y, vecs[v].y);
                check($sformatf("v%0d_lat", v), got_q[0].cyc - drv_cyc, 2);
                check($sformatf("v%0d_done_dly", v), dcyc - got_q[0].cyc, 2);
            end
        end

        // 70 keypoints with the output stalled: 64 kept, overflow flagged
        got_q.delete();
        kp_ready = 1'b0;
        start_frame();
        blank_lines(16);
        pixel_line(86, 16, 85, 8'h55);
        end_frame();
        repeat (5) step();
        check("full_count", kp_count, 64);
        check("full_ovf", overflow, 1);
        check("full_valid", kp_valid, 1);
        check("full_head_x", kp_x, 16);
        check("full_head_y", kp_y, 16);
        check("full_no_done", frame_done, 0);
        kp_ready = 1'b1;
        wait_done(found, late, dcyc);
        check("full_done", found, 1);
        check("full_late", late, 0);
        check_run("full", 16, 64);
        check("full_count_hold", kp_count, 64);

        // 600 keypoints with ready high: capped at 500, no overflow
        got_q.delete();
        start_frame();
        blank_lines(16);
        pixel_line(616, 16, 615, 8'h01);
        end_frame();
        wait_done(found, late, dcyc);
        check("cap_done", found, 1);
        check("cap_count", kp_count, 500);
        check("cap_ovf", overflow, 0);
        check_run("cap", 16, 500);

        // New frame while 5 entries remain in DRAIN
        got_q.delete();
        kp_ready = 1'b0;
        start_frame();
        blank_lines(16);
        pixel_line(25, 20, 24, 8'h07);
        end_frame();
        repeat (4) step();
        check("late_pending_x", kp_x, 20);
        check("late_pending_cnt", kp_count, 5);
        vs = 1'b1;
        #1;
        check("late_done", frame_done, 1);
        check("late_flag", frame_late, 1);
        step();
        check("late_count_clr", kp_count, 0);
        kp_ready = 1'b1;
        blank_lines(16);
        pixel_line(32, 30, 31, 8'h02);
        end_frame();
        wait_done(found, late, dcyc);
        check("late_next_done", found, 1);
        check("late_next_late", late, 0);
        check("late_next_count", kp_count, 2);
        check("late_beats", got_q.size(), 7);
        exp_x = '{20, 21, 22, 23, 24, 30, 31};
        bad = 0;
        for (int i = 0; i < got_q.size() && i < 7; i++)
            if (got_q[i].x != exp_x[i] || got_q[i].y != 16) bad++;
        check("late_order", bad, 0);

        // Reset mid-frame with 3 queued keypoints
        got_q.delete();
        kp_ready = 1'b0;
        start_frame();
        blank_lines(16);
        pixel_line(44, 40, 42, 8'h03);
        repeat (3) step();
        check("mrst_pre_valid", kp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", kp_valid, 0);
        check("mrst_count", kp_count, 0);
        step();
        step();
        rst_n = 1'b1;
        kp_ready = 1'b1;
        blank_lines(16);
        pixel_line(44, 40, 42, 8'h03);
        repeat (10) step();
        check("mrst_no_beats", got_q.size(), 0);
        check("mrst_idle_count", kp_count, 0);
        check("mrst_idle_valid", kp_valid, 0);
        vs = 1'b0;
        step();
        step();
        start_frame();
        blank_lines(16);
        pixel_line(17, 16, 16, 8'h09);
        end_frame();
        wait_done(found, late, dcyc);
        check("mrst_new_done", found, 1);
        check_run("mrst_new", 16, 1);
        check("mrst_new_count", kp_count, 1);

        check("stall_stable", stall_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fast_keypoint_scheduler.md
FAST_KEYPOINT_SCHEDULER -- requirements
Module: fast_keypoint_scheduler

Interface
REQ-001 SHALL have parameter P_IMG_WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter P_IMG_HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter P_BORDER, default 16, excluded margin in pixels on each image edge.
REQ-004 SHALL have parameter P_FIFO_DEPTH, default 64, keypoint FIFO entries, power of two.
REQ-005 SHALL have parameter P_MAX_KP, default 500, maximum keypoints accepted per frame.
REQ-006 SHALL have these ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fast_vs  in  1  frame valid, high for the whole frame.
- i_fast_hs  in  1  line valid.
- i_fast_en  in  1  pixel valid.
- i_fast_data  in  8  NMS output; nonzero marks a keypoint.
- o_kp_valid  out  1  keypoint available.
- i_kp_ready  in  1  downstream accepts the keypoint.
- o_kp_x  out  16  keypoint column.
- o_kp_y  out  16  keypoint row.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_frame_late  out  1  qualifies o_frame_done: the drain was incomplete.
- o_kp_count  out  16  keypoints accepted in the current or last frame.
- o_overflow  out  1  sticky flag: a keypoint was dropped because the FIFO was full.

Function
REQ-007 SHALL run an FSM with states IDLE, ACTIVE, DRAIN and DONE.
REQ-008 SHALL make these FSM transitions:
- IDLE->ACTIVE on a rising edge of i_fast_vs.
- ACTIVE->DRAIN on a falling edge of i_fast_vs.
- DRAIN->DONE when the FIFO is empty and no beat is pending on the output.
- DONE->IDLE unconditionally after one cycle.
REQ-009 SHALL set the counters from registered edge detection:
- x counter clears on each i_fast_hs rising edge and increments on every i_fast_en while in ACTIVE.
- y counter clears on the i_fast_vs rising edge and increments on each i_fast_hs falling edge.
REQ-010 SHALL accept a keypoint only when all of the following hold: i_fast_en, i_fast_data!=0, P_BORDER<=x<=P_IMG_WIDTH-1-P_BORDER, P_BORDER<=y<=P_IMG_HEIGHT-1-P_BORDER, o_kp_count<P_MAX_KP, and state ACTIVE.
REQ-011 SHALL, when a keypoint is accepted and the FIFO is not full, write {y,x} and increment o_kp_count.
REQ-012 SHALL, when a keypoint is accepted and the FIFO is full, drop it, set o_overflow, and leave o_kp_count unchanged.
REQ-013 SHALL drop keypoints after o_kp_count reaches P_MAX_KP silently, without setting o_overflow.
REQ-014 SHALL give 2 cycles of latency from a qualifying pixel to o_kp_valid when the FIFO is empty; o_kp_x and o_kp_y are registered.
REQ-015 SHALL use a valid/ready handshake on the output:
- Transfer when o_kp_valid && i_kp_ready.
- o_kp_valid, o_kp_x and o_kp_y hold stable while o_kp_valid && !i_kp_ready.
- o_kp_valid never depends combinationally on i_kp_ready.
REQ-016 SHALL sustain one write and one read per cycle on a full FIFO.
REQ-017 SHALL deliver keypoints in raster order.
REQ-018 SHALL pulse o_frame_done for exactly one cycle on entering DONE, with o_frame_late=0.
REQ-019 SHALL, on an i_fast_vs rising edge in DRAIN:
- Pulse o_frame_done with o_frame_late=1 in that cycle.
- Go to ACTIVE.
- Retain remaining FIFO entries, which drain ahead of the new frame's keypoints.
REQ-020 SHALL clear o_kp_count and o_overflow on every i_fast_vs rising edge; o_kp_count holds its value through DRAIN, DONE and IDLE.
REQ-021 SHALL treat i_fast_hs and i_fast_en as ignored outside ACTIVE.

Reset
REQ-022 SHALL, on i_rst_n low, asynchronously set the following:
- FSM to IDLE.
- FIFO pointers to 0.
- Counters to 0.
- o_kp_valid=0, o_kp_x=0, o_kp_y=0.
- o_frame_done=0, o_frame_late=0.
- o_kp_count=0, o_overflow=0.
REQ-023 SHALL, after reset mid-frame, ignore input until the next i_fast_vs rising edge and discard any FIFO contents.

Configuration
REQ-024 SHALL, when the macro FAST_KP_SCORE_EN is defined, add the output o_kp_score[7:0], carrying i_fast_data stored with each entry, with the FIFO 40 bits wide.
REQ-025 SHALL, when FAST_KP_SCORE_EN is undefined, omit o_kp_score and use a 32-bit FIFO, with all other behaviour identical.

Verification
REQ-026 SHALL cover: single keypoint at x=100,y=50 with i_kp_ready=1 -> o_kp_valid 2 cycles later with x=100,y=50, o_kp_count=1, then o_frame_done one cycle after drain.
REQ-027 SHALL cover: keypoints at x=10,y=50 and x=100,y=470 -> both dropped, o_kp_count=0, o_overflow=0.
REQ-028 SHALL cover: i_kp_ready=0 for a whole frame containing 70 qualifying keypoints -> 64 stored, o_overflow=1, o_kp_count=64, and o_kp_x/o_kp_y stable while stalled.
REQ-029 SHALL cover: 600 qualifying keypoints with i_kp_ready=1 -> exactly 500 delivered, o_kp_count=500, o_overflow=0.
REQ-030 SHALL cover: new i_fast_vs rising edge while 5 entries remain in DRAIN -> o_frame_done=1 with o_frame_late=1, then the 5 old entries precede new-frame keypoints.
REQ-031 SHALL cover: i_rst_n asserted mid-frame with 3 queued keypoints -> o_kp_valid=0 immediately and no output until a new frame.
